ma_bcd_display: RTL and testbench

- Downstream consumer of the moving-average block.
- Takes the 8-bit simple-average and EMA results and converts each to 3 BCD digits using a sequential shift-add-3 (double-dabble) engine.
- Drives six static active-low seven-segment displays: HEX2..HEX0 show the average, HEX5..HEX3 show the EMA.
- Reconverts only when an input value differs from the last converted value.

---
 rtl/ma_bcd_display.sv | 146 ++++++++++++++
 tb/tb_ma_bcd_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ma_bcd_display.sv
// ma_bcd_display: turns the 8-bit simple-average and EMA values into three
// BCD digits each with a sequential double-dabble engine, and drives six
// static active-low seven-segment displays (HEX2..0 = avg, HEX5..3 = EMA).
// A new conversion runs only when the inputs differ from the last captured pair.
module ma_bcd_display #(
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] avg_in,
    input  logic [7:0] ema_in,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       busy,
    output logic       upd
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    // Leading digits power up blank unless the display always shows 3 digits
    localparam logic [6:0] LEAD_RST  = (BLANK_LZ != 0) ? SEG_BLANK : SEG_ZERO;

    logic [1:0]  state;
    logic [2:0]  iter;
    logic [7:0]  cap_avg;
    logic [7:0]  cap_ema;
    // Shift registers hold {bcd[11:0], bin[7:0]} per channel
    logic [19:0] sh_avg;
    logic [19:0] sh_ema;
    logic        start;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // BCD nibble to active-low segments (g..a); out-of-range nibbles go blank
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Three BCD digits to {hundreds, tens, ones} segments with optional leading-zero blanking
    function automatic logic [20:0] digits_to_seg(input logic [11:0] bcd);
        logic [6:0] s2, s1, s0;
        s2 = seg_code(bcd[11:8]);
        s1 = seg_code(bcd[7:4]);
        s0 = seg_code(bcd[3:0]);
        if (BLANK_LZ != 0) begin
            if (bcd[11:8] == 4'd0) s2 = SEG_BLANK;
            if (bcd[11:4] == 8'd0) s1 = SEG_BLANK;
        end
        return {s2, s1, s0};
    endfunction

    assign start = (state == IDLE) && ({avg_in, ema_in} != {cap_avg, cap_ema});

    // Control FSM: capture on change, 8 conversion iterations, then one write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            iter    <= 3'd0;
            cap_avg <= 8'd0;
            cap_ema <= 8'd0;
            busy    <= 1'b0;
            upd     <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_avg <= avg_in;
                        cap_ema <= ema_in;
                        iter    <= 3'd0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) state <= WRITE;
                end
                WRITE: begin
                    upd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Conversion datapath: load on capture, shift-add-3 both channels in parallel
    always_ff @(posedge clk) begin
        if (start) begin
            sh_avg <= {12'd0, avg_in};
            sh_ema <= {12'd0, ema_in};
        end else if (state == CONV) begin
            sh_avg <= dabble_step(sh_avg);
            sh_ema <= dabble_step(sh_ema);
        end
    end

    // Display registers: hold during conversion, load decoded digits on the write cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex0 <= SEG_ZERO;
            hex1 <= LEAD_RST;
            hex2 <= LEAD_RST;
            hex3 <= SEG_ZERO;
            hex4 <= LEAD_RST;
            hex5 <= LEAD_RST;
        end else if (state == WRITE) begin
            {hex2, hex1, hex0} <= digits_to_seg(sh_avg[19:8]);
            {hex5, hex4, hex3} <= digits_to_seg(sh_ema[19:8]);
        end
    end

endmodule

// File: tb/tb_ma_bcd_display.sv
// Testbench for ma_bcd_display: two instances (leading-zero blanking on/off)
// share inputs; directed and random values are compared with a decimal-digit
// reference model, plus timing of busy/upd, hold-during-busy and reset abort.
module tb_ma_bcd_display;

    logic       clk;
    logic       rst;
    logic [7:0] avg_in;
    logic [7:0] ema_in;
    logic [6:0] h0, h1, h2, h3, h4, h5;
    logic [6:0] z0, z1, z2, z3, z4, z5;
    logic       busy, upd, busy_z, upd_z;
    logic [41:0] out1, out0;

    int n_checks;
    int n_fail;
    int cap_a, cap_e, disp_a, disp_e;
    logic [6:0] seg_tab [0:9];

    ma_bcd_display #(.BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .avg_in(avg_in), .ema_in(ema_in),
        .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4), .hex5(h5),
        .busy(busy), .upd(upd)
    );

    ma_bcd_display #(.BLANK_LZ(0)) dut_nlz (
        .clk(clk), .rst(rst), .avg_in(avg_in), .ema_in(ema_in),
        .hex0(z0), .hex1(z1), .hex2(z2), .hex3(z3), .hex4(z4), .hex5(z5),
        .busy(busy_z), .upd(upd_z)
    );

    assign out1 = {h5, h4, h3, h2, h1, h0};
    assign out0 = {z5, z4, z3, z2, z1, z0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One channel: decimal digits by arithmetic, blanking by value
    function automatic logic [20:0] chan_model(input int v, input bit blz);
        logic [6:0] s2, s1, s0;
        s2 = seg_tab[v / 100];
        s1 = seg_tab[(v / 10) % 10];
        s0 = seg_tab[v % 10];
        if (blz && v < 100) s2 = 7'h7F;
        if (blz && v < 10)  s1 = 7'h7F;
        return {s2, s1, s0};
    endfunction

    function automatic logic [41:0] disp_model(input int a, input int e, input bit blz);
        return {chan_model(e, blz), chan_model(a, blz)};
    endfunction

    // Apply a value pair and observe 24 cycles of busy/upd/display behaviour
    task automatic convert(input int a, input int e);
        bit conv;
        int bstart, bcnt, ucyc, ucnt, bad, bz;
        logic [41:0] exp1, exp0;
        conv = (a != cap_a) || (e != cap_e);
        bstart = -1; bcnt = 0; ucyc = -1; ucnt = 0; bad = 0; bz = 0;
        avg_in = a[7:0];
        ema_in = e[7:0];
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (busy) begin
                if (bstart < 0) bstart = c;
                bcnt++;
            end
            if (busy_z != busy) bz++;
            if (upd) begin
                ucnt++;
                if (ucyc < 0) ucyc = c;
            end
            if (ucyc >= 0) begin
                exp1 = disp_model(a, e, 1'b1);
                exp0 = disp_model(a, e, 1'b0);
            end else begin
                exp1 = disp_model(disp_a, disp_e, 1'b1);
                exp0 = disp_model(disp_a, disp_e, 1'b0);
            end
            if (out1 !== exp1 || out0 !== exp0) bad++;
        end
        if (conv) begin
            cap_a = a; cap_e = e; disp_a = a; disp_e = e;
        end
        check("busy_len", 64'(bcnt), conv ? 64'd9 : 64'd0);
        check("upd_cnt", 64'(ucnt), conv ? 64'd1 : 64'd0);
        if (conv) begin
            check("busy_start", 64'(bstart), 64'd0);
            check("upd_at", 64'(ucyc), 64'd9);
        end
        check("busy_match", 64'(bz), 64'd0);
        check("disp_hold", 64'(bad), 64'd0);
        check("disp", 64'(out1), 64'(disp_model(a, e, 1'b1)));
        check("disp_nlz", 64'(out0), 64'(disp_model(a, e, 1'b0)));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_disp"}, 64'(out1), 64'(disp_model(0, 0, 1'b1)));
        check({tag, "_disp_nlz"}, 64'(out0), 64'(disp_model(0, 0, 1'b0)));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_upd"}, 64'(upd), 64'd0);
    endtask

    initial begin
        int a, e, r, ucnt, u1, u2, bcnt;
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        n_checks = 0; n_fail = 0;
        cap_a = 0; cap_e = 0; disp_a = 0; disp_e = 0;
        rst = 1'b1; avg_in = 8'd0; ema_in = 8'd0;

        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;

        // Zero inputs after reset: nothing to convert
        bcnt = 0; ucnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (upd) ucnt++;
        end
        check("idle_busy", 64'(bcnt), 64'd0);
        check("idle_upd", 64'(ucnt), 64'd0);
        check_reset_values("idle");

        // Directed values
        convert(12, 7);
        convert(255, 100);
        convert(5, 100);
        convert(5, 0);
        convert(5, 0);
        convert(99, 9);
        convert(100, 10);

        // Input change during conversion: 9 shown first, then 3
        avg_in = 8'd9;
        ucnt = 0; u1 = -1; u2 = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (upd) begin
                ucnt++;
                if (u1 < 0) u1 = c; else if (u2 < 0) u2 = c;
            end
            if (c == 9) check("mid_first", 64'(out1), 64'(disp_model(9, cap_e, 1'b1)));
            if (c == 19) check("mid_second", 64'(out1), 64'(disp_model(3, cap_e, 1'b1)));
            if (c == 3) avg_in = 8'd3;
        end
        check("mid_upd_cnt", 64'(ucnt), 64'd2);
        check("mid_upd1", 64'(u1), 64'd9);
        check("mid_upd2", 64'(u2), 64'd19);
        cap_a = 3; disp_a = 3;

        // Reset in the middle of a conversion of 200
        avg_in = 8'd200;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_values("abort");
        @(negedge clk);
        rst = 1'b0;
        cap_a = 0; cap_e = 0; disp_a = 0; disp_e = 0;
        convert(200, cap_e == 0 ? int'(ema_in) : 0);

        // Randomized values, some repeating one or both channels
        for (int i = 0; i < 14; i++) begin
            r = int'($urandom_range(0, 3));
            a = (r == 0 || r == 3) ? cap_a : int'($urandom_range(0, 255));
            e = (r == 1 || r == 3) ? cap_e : int'($urandom_range(0, 255));
            convert(a, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
